// File: rtl/flash16_wb_ctrl.sv
// Wishbone slave for a 16-bit parallel NOR flash: every 32-bit access is two 16-bit halves.
// Define FLASH16_WRITE_EN to enable 16-bit programming writes; otherwise writes ack with no flash activity.
module flash16_wb_ctrl #(
    parameter int ADR_WIDTH = 24,
    parameter int RD_TIMING = 12,
    parameter int WR_TIMING = 15
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst,
    input  logic [ADR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]          wb_dat_i,
    input  logic [3:0]           wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_stb_i,
    input  logic                 wb_cyc_i,
    output logic [31:0]          wb_dat_o,
    output logic                 wb_ack_o,
    output logic [ADR_WIDTH-1:0] flash_adr,
    input  logic [15:0]          flash_d_i,
    output logic [15:0]          flash_d_o,
    output logic                 flash_d_oe,
    output logic                 flash_ce_n,
    output logic                 flash_oe_n,
    output logic                 flash_we_n
);

    localparam logic [3:0] RD_LOAD = 4'(RD_TIMING - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_TIMING - 1);

`ifdef FLASH16_WRITE_EN
    typedef enum logic [2:0] {IDLE, RD_HI, RD_LO, ACK, WR_SETUP, WR_PULSE, WR_HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, ACK} state_t;
`endif

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [31:0]            dat_q, dat_d;
    logic                   ack_q, ack_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   req;
    logic                   busy;
    logic [ADR_WIDTH-1:0]   word_adr;

`ifdef FLASH16_WRITE_EN
    logic [15:0]            d_o_q, d_o_d;
    logic                   d_oe_q, d_oe_d;
    logic                   we_n_q, we_n_d;
    logic [15:0]            lo_dat_q, lo_dat_d;
    logic                   lo_pend_q, lo_pend_d;
    logic                   unused_ok;

    assign unused_ok = ^wb_adr_i[1:0];
`else
    logic                   unused_ok;

    assign unused_ok = ^{wb_dat_i, wb_sel_i, wb_adr_i[1:0], WR_LOAD};
`endif

    assign req      = wb_cyc_i & wb_stb_i & ~ack_q;
    assign word_adr = {wb_adr_i[ADR_WIDTH-1:2], 2'b00};

    always_comb begin
        busy = (state_q == RD_HI) || (state_q == RD_LO);
`ifdef FLASH16_WRITE_EN
        busy = busy || (state_q == WR_SETUP) || (state_q == WR_PULSE) || (state_q == WR_HOLD);
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
`ifdef FLASH16_WRITE_EN
        d_o_d     = d_o_q;
        d_oe_d    = d_oe_q;
        we_n_d    = we_n_q;
        lo_dat_d  = lo_dat_q;
        lo_pend_d = lo_pend_q;
`endif

        // Losing the cycle mid-transfer releases the pads at once; partial read data is kept.
        if (busy && !wb_cyc_i) begin
            state_d = IDLE;
            cnt_d   = 4'd0;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
`ifdef FLASH16_WRITE_EN
            we_n_d    = 1'b1;
            d_oe_d    = 1'b0;
            lo_pend_d = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        if (!wb_we_i) begin
                            state_d = RD_HI;
                            cnt_d   = RD_LOAD;
                            adr_d   = word_adr;
                            ce_n_d  = 1'b0;
                            oe_n_d  = 1'b0;
                        end else begin
`ifdef FLASH16_WRITE_EN
                            if (wb_sel_i[3:2] == 2'b11) begin
                                state_d   = WR_SETUP;
                                adr_d     = word_adr;
                                d_o_d     = wb_dat_i[31:16];
                                d_oe_d    = 1'b1;
                                ce_n_d    = 1'b0;
                                lo_dat_d  = wb_dat_i[15:0];
                                lo_pend_d = (wb_sel_i[1:0] == 2'b11);
                            end else if (wb_sel_i[1:0] == 2'b11) begin
                                state_d   = WR_SETUP;
                                adr_d     = {wb_adr_i[ADR_WIDTH-1:2], 2'b10};
                                d_o_d     = wb_dat_i[15:0];
                                d_oe_d    = 1'b1;
                                ce_n_d    = 1'b0;
                                lo_pend_d = 1'b0;
                            end else begin
                                state_d = ACK;
                                ack_d   = 1'b1;
                            end
`else
                            state_d = ACK;
                            ack_d   = 1'b1;
`endif
                        end
                    end
                end
                RD_HI: begin
                    if (cnt_q == 4'd0) begin
                        dat_d[31:16] = flash_d_i;
                        adr_d[1]     = 1'b1;
                        state_d      = RD_LO;
                        cnt_d        = RD_LOAD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                RD_LO: begin
                    if (cnt_q == 4'd0) begin
                        dat_d[15:0] = flash_d_i;
                        ce_n_d      = 1'b1;
                        oe_n_d      = 1'b1;
                        state_d     = ACK;
                        ack_d       = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ACK: begin
                    state_d = IDLE;
                end
`ifdef FLASH16_WRITE_EN
                WR_SETUP: begin
                    state_d = WR_PULSE;
                    cnt_d   = WR_LOAD;
                    we_n_d  = 1'b0;
                end
                WR_PULSE: begin
                    if (cnt_q == 4'd0) begin
                        state_d = WR_HOLD;
                        we_n_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                // Hold keeps address and data on the pads one cycle past the rising we_n edge.
                WR_HOLD: begin
                    if (lo_pend_q) begin
                        state_d   = WR_SETUP;
                        adr_d[1]  = 1'b1;
                        d_o_d     = lo_dat_q;
                        lo_pend_d = 1'b0;
                    end else begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                        d_oe_d  = 1'b0;
                        ce_n_d  = 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            dat_q   <= 32'd0;
            ack_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

`ifdef FLASH16_WRITE_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            d_o_q     <= 16'd0;
            d_oe_q    <= 1'b0;
            we_n_q    <= 1'b1;
            lo_dat_q  <= 16'd0;
            lo_pend_q <= 1'b0;
        end else begin
            d_o_q     <= d_o_d;
            d_oe_q    <= d_oe_d;
            we_n_q    <= we_n_d;
            lo_dat_q  <= lo_dat_d;
            lo_pend_q <= lo_pend_d;
        end
    end

    assign flash_d_o  = d_o_q;
    assign flash_d_oe = d_oe_q;
    assign flash_we_n = we_n_q;
`else
    assign flash_d_o  = 16'd0;
    assign flash_d_oe = 1'b0;
    assign flash_we_n = 1'b1;
`endif

    assign wb_dat_o   = dat_q;
    assign wb_ack_o   = ack_q;
    assign flash_adr  = adr_q;
    assign flash_ce_n = ce_n_q;
    assign flash_oe_n = oe_n_q;

endmodule

// File: tb/tb_flash16_wb_ctrl.sv
// Randomized bench for flash16_wb_ctrl: a 256-halfword flash pad model plus a reference word store.
// Write expectations follow FLASH16_WRITE_EN the same way the design build does.
module tb_flash16_wb_ctrl;

    localparam int RD_T = 12;
    localparam int WR_T = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_cyc = 1'b0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic [23:0] flash_adr;
    logic [15:0] flash_d_i;
    logic [15:0] flash_d_o;
    logic        flash_d_oe;
    logic        flash_ce_n;
    logic        flash_oe_n;
    logic        flash_we_n;

    logic [15:0] flash_mem [256];
    logic [15:0] ref_mem   [256];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign flash_d_i = (!flash_ce_n && !flash_oe_n) ? flash_mem[flash_adr[8:1]] : 16'hFFFF;

    flash16_wb_ctrl #(.ADR_WIDTH(24), .RD_TIMING(RD_T), .WR_TIMING(WR_T)) dut (
        .sys_clk(clk), .sys_rst(rst),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat), .wb_sel_i(wb_sel), .wb_we_i(wb_we),
        .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
        .flash_adr(flash_adr), .flash_d_i(flash_d_i), .flash_d_o(flash_d_o),
        .flash_d_oe(flash_d_oe), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
        .flash_we_n(flash_we_n)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    endtask

    function automatic logic [31:0] model_word(input logic [23:0] a);
        logic [7:0] idx;
        idx = {a[8:2], 1'b0};
        return {ref_mem[idx], ref_mem[idx | 8'd1]};
    endfunction

    task automatic check_idle_pads(input string tag);
        check_val({tag, "_ce_n"}, 32'(flash_ce_n), 32'd1);
        check_val({tag, "_oe_n"}, 32'(flash_oe_n), 32'd1);
        check_val({tag, "_we_n"}, 32'(flash_we_n), 32'd1);
        check_val({tag, "_d_oe"}, 32'(flash_d_oe), 32'd0);
        check_val({tag, "_ack"},  32'(wb_ack_o),   32'd0);
    endtask

    // b2b: request already held through the previous ACK; keep: leave the request up afterwards.
    task automatic read_txn(input logic [23:0] a, input bit b2b, input bit keep);
        int ack_k, hi_n, lo_n, ce_hi;
        logic [31:0] exp;
        logic [31:0] got_dat;
        exp = model_word(a);
        if (!b2b) @(negedge clk);
        wb_adr = a; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        ack_k = 0; hi_n = 0; lo_n = 0; ce_hi = 0; got_dat = '0;
        for (int k = 1; k <= 80 && ack_k == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (!flash_ce_n && !flash_oe_n && flash_adr == {a[23:2], 2'b00}) hi_n++;
            if (!flash_ce_n && !flash_oe_n && flash_adr == {a[23:2], 2'b10}) lo_n++;
            if (wb_ack_o) begin
                ack_k = k;
                got_dat = wb_dat_o;
            end else if (flash_ce_n) begin
                ce_hi++;
            end
        end
        check_val("rd_ack_latency", 32'(ack_k), 32'(2 * RD_T + 1 + (b2b ? 1 : 0)));
        check_val("rd_data", got_dat, exp);
        check_val("rd_hi_cycles", 32'(hi_n), 32'(RD_T));
        check_val("rd_lo_cycles", 32'(lo_n), 32'(RD_T));
        check_val("rd_ce_high_gap", 32'(ce_hi), 32'(b2b ? 1 : 0));
        if (!keep) begin
            wb_cyc = 1'b0; wb_stb = 1'b0;
        end
    endtask

    task automatic write_txn(input logic [23:0] a, input logic [31:0] d, input logic [3:0] s);
        int ack_k, n_exp, pulse_n, bad_val, ce_low, oe_bad, exp_lat;
        int len [2];
        logic [23:0] exp_adr [2];
        logic [15:0] exp_dat [2];
        bit prev_low;
        n_exp = 0;
        exp_adr[0] = '0; exp_adr[1] = '0; exp_dat[0] = '0; exp_dat[1] = '0;
`ifdef FLASH16_WRITE_EN
        if (s[3:2] == 2'b11) begin
            exp_adr[n_exp] = {a[23:2], 2'b00}; exp_dat[n_exp] = d[31:16]; n_exp++;
        end
        if (s[1:0] == 2'b11) begin
            exp_adr[n_exp] = {a[23:2], 2'b10}; exp_dat[n_exp] = d[15:0]; n_exp++;
        end
`endif
        @(negedge clk);
        wb_adr = a; wb_dat = d; wb_sel = s; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
        ack_k = 0; pulse_n = 0; bad_val = 0; ce_low = 0; oe_bad = 0; prev_low = 1'b0;
        len[0] = 0; len[1] = 0;
        for (int k = 1; k <= 80 && ack_k == 0; k++) begin
            @(posedge clk); @(negedge clk);
            if (!flash_ce_n) ce_low++;
            if (flash_d_oe && !flash_oe_n) oe_bad++;
            if (!flash_we_n) begin
                if (!prev_low) pulse_n++;
                if (pulse_n <= n_exp) begin
                    len[pulse_n-1]++;
                    if (flash_adr != exp_adr[pulse_n-1] || flash_d_o != exp_dat[pulse_n-1] ||
                        !flash_d_oe || flash_ce_n) bad_val++;
                end else begin
                    bad_val++;
                end
            end else if (prev_low && !flash_ce_n) begin
                flash_mem[flash_adr[8:1]] = flash_d_o;
            end
            prev_low = !flash_we_n;
            if (wb_ack_o) ack_k = k;
        end
        exp_lat = (n_exp == 0) ? 1 : n_exp * (WR_T + 2) + 1;
        check_val("wr_ack_latency", 32'(ack_k), 32'(exp_lat));
        check_val("wr_pulses", 32'(pulse_n), 32'(n_exp));
        check_val("wr_pad_values", 32'(bad_val), 32'd0);
        check_val("wr_pulse0_len", 32'(len[0]), 32'(n_exp > 0 ? WR_T : 0));
        check_val("wr_pulse1_len", 32'(len[1]), 32'(n_exp > 1 ? WR_T : 0));
        check_val("wr_oe_contention", 32'(oe_bad), 32'd0);
        if (n_exp == 0) check_val("wr_noop_ce_low", 32'(ce_low), 32'd0);
        for (int i = 0; i < n_exp; i++) ref_mem[exp_adr[i][8:1]] = exp_dat[i];
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic abort_read(input logic [23:0] a);
        int acks;
        @(negedge clk);
        wb_adr = a; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        acks = 0;
        for (int k = 1; k <= 35; k++) begin
            @(posedge clk); @(negedge clk);
            if (wb_ack_o) acks++;
            if (k == 5) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
            if (k == 6) check_idle_pads("abort");
        end
        check_val("abort_no_ack", 32'(acks), 32'd0);
    endtask

    task automatic reset_mid_read(input logic [23:0] a);
        @(negedge clk);
        wb_adr = a; wb_we = 1'b0; wb_sel = 4'hF; wb_cyc = 1'b1; wb_stb = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); @(negedge clk);
        end
        check_val("pre_reset_ce_low", 32'(flash_ce_n), 32'd0);
        rst = 1'b1;
        #1;
        check_idle_pads("async_rst");
        check_val("async_rst_adr", 32'(flash_adr), 32'd0);
        check_val("async_rst_dat", wb_dat_o, 32'd0);
        @(negedge clk);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 256; i++) begin
            flash_mem[i] = 16'($urandom());
            ref_mem[i]   = flash_mem[i];
        end
        flash_mem[8] = 16'h1234; ref_mem[8] = 16'h1234;
        flash_mem[9] = 16'h5678; ref_mem[9] = 16'h5678;

        repeat (3) @(negedge clk);
        check_idle_pads("reset");
        check_val("reset_adr", 32'(flash_adr), 32'd0);
        check_val("reset_dat", wb_dat_o, 32'd0);
        check_val("reset_d_o", 32'(flash_d_o), 32'd0);
        rst = 1'b0;

        check_val("model_word_0x10", model_word(24'h000010), 32'h12345678);
        read_txn(24'h000010, 1'b0, 1'b0);

        read_txn(24'h000000, 1'b0, 1'b1);
        read_txn(24'h000004, 1'b1, 1'b0);

        abort_read(24'h000010);
        read_txn(24'h000010, 1'b0, 1'b0);

        reset_mid_read(24'h000018);
        read_txn(24'h000018, 1'b0, 1'b0);

        write_txn(24'h000020, 32'hDEADBEEF, 4'hF);
        read_txn(24'h000020, 1'b0, 1'b0);
        write_txn(24'h000030, 32'hCAFEF00D, 4'b0100);
        read_txn(24'h000030, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            a = 24'($urandom()) & 24'hFFFFFC;
            d = $urandom();
            case (i % 4)
                0: s = 4'hF;
                1: s = 4'hC;
                2: s = 4'h3;
                default: s = 4'($urandom());
            endcase
            write_txn(a, d, s);
            read_txn(a, 1'b0, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            a = 24'($urandom()) & 24'hFFFFFC;
            read_txn(a, 1'b0, (i == 2));
            if (i == 2) begin
                a = 24'($urandom()) & 24'hFFFFFC;
                read_txn(a, 1'b1, 1'b0);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
